retire: RTL and testbench

- Retire/writeback stage directly downstream of the execute stage.
- Each cycle it captures the EX1 micro-op and result into an RB1 stage register, writes the architectural register file, and counts retired instructions.
- On a retiring branch mispredict it raises br_mispred_rb1, which the execute stage uses to kill its EX1 slot, and issues a front-end redirect.
- After a mispredict it runs a flush FSM that discards wrong-path micro-ops still draining through the pipe.

---
 rtl/retire_pkg.sv | 27 ++
 rtl/retire.sv | 116 +++++++++++
 tb/tb_retire.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_pkg.sv
// Shared types for the retire/writeback stage: micro-op layout, register data and physical address.
package retire_pkg;
    localparam int XLEN    = 64;
    localparam int PADDR_W = 40;

    typedef logic [XLEN-1:0]    t_rv_reg_data;
    typedef logic [PADDR_W-1:0] t_paddr;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_REG  = 2'd1,
        OP_IMM  = 2'd2,
        OP_CSR  = 2'd3
    } t_optype;

    typedef struct packed {
        t_optype    optype;
        logic [4:0] opreg;
    } t_dst;

    typedef struct packed {
        logic   valid;
        logic   mispred;
        t_paddr pc;
        t_dst   dst;
    } t_uinstr;
endpackage

// File: rtl/retire.sv
// Retire/writeback stage: RB1 stage register, register-file write, retirement counters,
// and a flush FSM that drops wrong-path micro-ops for FLUSH_CYCLES cycles after a mispredict.
module retire
    import retire_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  t_uinstr          uinstr_ex1,
    input  t_rv_reg_data     result_ex1,
    output logic             br_mispred_rb1,
    output logic             redirect_vld_rb1,
    output t_paddr           redirect_pc_rb1,
    output logic             wr_en_rb1,
    output logic [4:0]       wr_addr_rb1,
    output t_rv_reg_data     wr_data_rb1,
    output logic [CNT_W-1:0] instret,
    output logic [31:0]      mispred_cnt,
    output logic             flushing
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } t_state;

    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

    t_state             state_q, state_d;
    logic [3:0]         fcnt_q, fcnt_d;
    t_uinstr            uinstr_rb1_q, uinstr_rb1_d;
    t_rv_reg_data       result_rb1_q, result_rb1_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;
    logic               retire_rb1;
    logic               unused_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= RUN;
            fcnt_q              <= 4'd0;
            instret_q           <= '0;
            mispred_cnt_q       <= 32'd0;
            uinstr_rb1_q        <= uinstr_rb1_d;
            uinstr_rb1_q.valid  <= 1'b0;
            result_rb1_q        <= result_rb1_d;
        end else begin
            state_q             <= state_d;
            fcnt_q              <= fcnt_d;
            instret_q           <= instret_d;
            mispred_cnt_q       <= mispred_cnt_d;
            uinstr_rb1_q        <= uinstr_rb1_d;
            result_rb1_q        <= result_rb1_d;
        end
    end

    always_comb begin
        uinstr_rb1_d     = stall ? uinstr_rb1_q : uinstr_ex1;
        result_rb1_d     = stall ? result_rb1_q : result_ex1;

        // Outputs are forced quiet while reset is held so nothing retires during reset.
        retire_rb1       = uinstr_rb1_q.valid & ~stall & (state_q == RUN) & ~reset;
        br_mispred_rb1   = retire_rb1 & uinstr_rb1_q.mispred;
        redirect_vld_rb1 = br_mispred_rb1;
        redirect_pc_rb1  = result_rb1_q[PADDR_W-1:0];
        wr_en_rb1        = retire_rb1 & (uinstr_rb1_q.dst.optype == OP_REG)
                           & (uinstr_rb1_q.dst.opreg != 5'd0);
        wr_addr_rb1      = uinstr_rb1_q.dst.opreg;
        wr_data_rb1      = result_rb1_q;
        flushing         = (state_q == FLUSH) & ~reset;

        instret_d        = instret_q + {{(CNT_W-1){1'b0}}, retire_rb1};
        mispred_cnt_d    = mispred_cnt_q;
        if (br_mispred_rb1 && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end

        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (br_mispred_rb1) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                // Counter runs even under stall: the flush window is measured in cycles.
                if (fcnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    assign instret     = instret_q;
    assign mispred_cnt = mispred_cnt_q;
    assign unused_pc   = ^uinstr_rb1_q.pc;

    a_no_x0_write: assert property (@(posedge clk) disable iff (reset)
        wr_en_rb1 |-> (wr_addr_rb1 != 5'd0));
    a_mispred_redirect: assert property (@(posedge clk) disable iff (reset)
        br_mispred_rb1 |-> redirect_vld_rb1);
    a_fcnt_range: assert property (@(posedge clk) disable iff (reset)
        (state_q == FLUSH) |-> (fcnt_q <= FCNT_LOAD));

endmodule

// File: tb/tb_retire.sv
// Directed bench for retire: two instances (flush window 3 and 1) share stimulus and are
// checked every cycle against a discard-window model, plus hand-computed literal expectations.
module tb_retire;
    import retire_pkg::*;

    logic         clk;
    logic         reset;
    logic         stall;
    t_uinstr      uinstr_ex1;
    t_rv_reg_data result_ex1;

    logic [1:0]   br_mis, rd_vld, wr_en, flush_o;
    t_paddr       rd_pc   [2];
    logic [4:0]   wr_addr [2];
    t_rv_reg_data wr_data [2];
    logic [63:0]  instret [2];
    logic [31:0]  mcnt    [2];

    int checks = 0;
    int errors = 0;

    retire #(.FLUSH_CYCLES(3), .CNT_W(64)) dut3 (
        .clk(clk), .reset(reset), .stall(stall),
        .uinstr_ex1(uinstr_ex1), .result_ex1(result_ex1),
        .br_mispred_rb1(br_mis[0]), .redirect_vld_rb1(rd_vld[0]), .redirect_pc_rb1(rd_pc[0]),
        .wr_en_rb1(wr_en[0]), .wr_addr_rb1(wr_addr[0]), .wr_data_rb1(wr_data[0]),
        .instret(instret[0]), .mispred_cnt(mcnt[0]), .flushing(flush_o[0])
    );

    retire #(.FLUSH_CYCLES(1), .CNT_W(64)) dut1 (
        .clk(clk), .reset(reset), .stall(stall),
        .uinstr_ex1(uinstr_ex1), .result_ex1(result_ex1),
        .br_mispred_rb1(br_mis[1]), .redirect_vld_rb1(rd_vld[1]), .redirect_pc_rb1(rd_pc[1]),
        .wr_en_rb1(wr_en[1]), .wr_addr_rb1(wr_addr[1]), .wr_data_rb1(wr_data[1]),
        .instret(instret[1]), .mispred_cnt(mcnt[1]), .flushing(flush_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance discards for F cycles after a retiring mispredict; the stage slot is shared.
    int           flen       [2] = '{3, 1};
    int           flush_left [2];
    logic [63:0]  m_instret  [2];
    logic [31:0]  m_mcnt     [2];
    t_uinstr      m_uop;
    t_rv_reg_data m_res;
    logic         m_ret;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                flush_left[k] = 0;
                m_instret[k]  = 64'd0;
                m_mcnt[k]     = 32'd0;
            end else begin
                m_ret = m_uop.valid && !stall && (flush_left[k] == 0);
                if (flush_left[k] > 0) flush_left[k] = flush_left[k] - 1;
                if (m_ret) begin
                    m_instret[k] = m_instret[k] + 64'd1;
                    if (m_uop.mispred) begin
                        flush_left[k] = flen[k];
                        if (m_mcnt[k] != 32'hFFFF_FFFF) m_mcnt[k] = m_mcnt[k] + 32'd1;
                    end
                end
            end
        end
        if (!stall) begin
            m_uop = uinstr_ex1;
            m_res = result_ex1;
        end
        if (reset) m_uop.valid = 1'b0;
    end

    // ---------------- per-cycle compare ----------------
    t_rv_reg_data obs_rf [32];
    int           x0_writes = 0;
    int           x7_writes = 0;

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                logic ret, e_mis, e_wr, inf;
                inf   = (flush_left[k] != 0);
                ret   = m_uop.valid && !stall && !inf;
                e_mis = ret && m_uop.mispred;
                e_wr  = ret && (m_uop.dst.optype == OP_REG) && (m_uop.dst.opreg != 5'd0);
                cmp($sformatf("br_mispred[%0d]", k), 64'(br_mis[k]), 64'(e_mis));
                cmp($sformatf("redirect_vld[%0d]", k), 64'(rd_vld[k]), 64'(e_mis));
                if (e_mis) cmp($sformatf("redirect_pc[%0d]", k), 64'(rd_pc[k]), 64'(m_res[PADDR_W-1:0]));
                cmp($sformatf("wr_en[%0d]", k), 64'(wr_en[k]), 64'(e_wr));
                if (e_wr) begin
                    cmp($sformatf("wr_addr[%0d]", k), 64'(wr_addr[k]), 64'(m_uop.dst.opreg));
                    cmp($sformatf("wr_data[%0d]", k), wr_data[k], m_res);
                end
                cmp($sformatf("instret[%0d]", k), instret[k], m_instret[k]);
                cmp($sformatf("mispred_cnt[%0d]", k), 64'(mcnt[k]), 64'(m_mcnt[k]));
                cmp($sformatf("flushing[%0d]", k), 64'(flush_o[k]), 64'(inf));
            end
            if (wr_en[0]) begin
                obs_rf[wr_addr[0]] = wr_data[0];
                if (wr_addr[0] == 5'd7) x7_writes++;
            end
            if ((wr_en[0] && wr_addr[0] == 5'd0) || (wr_en[1] && wr_addr[1] == 5'd0)) x0_writes++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic t_uinstr mk(input logic v, input logic mp, input t_optype ot, input logic [4:0] r);
        t_uinstr u;
        u.valid      = v;
        u.mispred    = mp;
        u.pc         = 40'h00_1000_0000;
        u.dst.optype = ot;
        u.dst.opreg  = r;
        return u;
    endfunction

    // Inputs given here are captured at the following edge, so the op appears in RB1 during the
    // next step; returns at the negedge of the cycle in which these inputs are live.
    task automatic step(input t_uinstr u, input t_rv_reg_data r, input logic s, input logic rs);
        @(posedge clk);
        #1;
        uinstr_ex1 = u;
        result_ex1 = r;
        stall      = s;
        reset      = rs;
        @(negedge clk);
    endtask

    t_uinstr bub;

    initial begin
        bub        = mk(1'b0, 1'b0, OP_NONE, 5'd0);
        reset      = 1'b1;
        stall      = 1'b0;
        uinstr_ex1 = bub;
        result_ex1 = '0;
        for (int i = 0; i < 32; i++) obs_rf[i] = '0;

        step(bub, 0, 0, 1);
        step(bub, 0, 0, 1);
        step(bub, 0, 0, 0);
        cmp("rst_instret", instret[0], 64'd0);
        cmp("rst_flushing", 64'(flush_o[0]), 64'd0);
        cmp("rst_wr_en", 64'(wr_en[0]), 64'd0);
        cmp("rst_br", 64'(br_mis[1]), 64'd0);

        // Three ALU ops to x5, x6, x0
        step(mk(1, 0, OP_REG, 5'd5), 64'h11, 0, 0);
        step(mk(1, 0, OP_REG, 5'd6), 64'h22, 0, 0);
        step(mk(1, 0, OP_REG, 5'd0), 64'h33, 0, 0);
        step(bub, 0, 0, 0);
        step(bub, 0, 0, 0);
        cmp("t1_x5", obs_rf[5], 64'h11);
        cmp("t1_x6", obs_rf[6], 64'h22);
        cmp("t1_instret3", instret[0], 64'd3);
        cmp("t1_instret1", instret[1], 64'd3);
        cmp("t1_x0_writes", 64'(x0_writes), 64'd0);

        // x7 held under stall for 4 cycles
        step(mk(1, 0, OP_REG, 5'd7), 64'h77, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(bub, 0, 1, 0);
            cmp("t2_stall_wr_en", 64'(wr_en[0]), 64'd0);
            cmp("t2_stall_instret", instret[0], 64'd3);
        end
        step(bub, 0, 0, 0);
        cmp("t2_rel_wr_en", 64'(wr_en[0]), 64'd1);
        cmp("t2_rel_wr_addr", 64'(wr_addr[0]), 64'd7);
        step(bub, 0, 0, 0);
        cmp("t2_instret", instret[0], 64'd4);
        cmp("t2_x7_writes", 64'(x7_writes), 64'd1);

        // Mispredicting branch then four valid ops
        step(mk(1, 1, OP_NONE, 5'd0), 64'h8000_0040, 0, 0);
        step(mk(1, 0, OP_REG, 5'd1), 64'h1, 0, 0);
        cmp("t3_br", 64'(br_mis[0]), 64'd1);
        cmp("t3_redirect_pc", 64'(rd_pc[0]), 64'h8000_0040);
        step(mk(1, 0, OP_REG, 5'd2), 64'h2, 0, 0);
        cmp("t3_a_flush3", 64'(flush_o[0]), 64'd1);
        cmp("t3_a_flush1", 64'(flush_o[1]), 64'd1);
        cmp("t3_a_wr1", 64'(wr_en[1]), 64'd0);
        step(mk(1, 0, OP_REG, 5'd3), 64'h3, 0, 0);
        cmp("t3_b_flush3", 64'(flush_o[0]), 64'd1);
        cmp("t3_b_wr3", 64'(wr_en[0]), 64'd0);
        cmp("t3_b_wr1", 64'(wr_en[1]), 64'd1);
        step(mk(1, 0, OP_REG, 5'd4), 64'h4, 0, 0);
        cmp("t3_c_flush3", 64'(flush_o[0]), 64'd1);
        step(bub, 0, 0, 0);
        cmp("t3_d_flush3", 64'(flush_o[0]), 64'd0);
        cmp("t3_d_wr3", 64'(wr_en[0]), 64'd1);
        cmp("t3_d_addr3", 64'(wr_addr[0]), 64'd4);
        step(bub, 0, 0, 0);
        cmp("t3_mcnt3", 64'(mcnt[0]), 64'd1);
        cmp("t3_mcnt1", 64'(mcnt[1]), 64'd1);
        cmp("t3_instret3", instret[0], 64'd6);
        cmp("t3_instret1", instret[1], 64'd8);

        // Stalled mispredict, then a wrong-path op carrying mispred during FLUSH
        step(mk(1, 1, OP_NONE, 5'd0), 64'h8000_0100, 0, 0);
        step(bub, 0, 1, 0);
        cmp("t4_stall_br", 64'(br_mis[0]), 64'd0);
        step(bub, 0, 1, 0);
        step(mk(1, 1, OP_REG, 5'd10), 64'hA, 0, 0);
        cmp("t4_rel_br", 64'(br_mis[0]), 64'd1);
        cmp("t4_rel_pc", 64'(rd_pc[0]), 64'h8000_0100);
        step(bub, 0, 0, 0);
        cmp("t4_wp_br3", 64'(br_mis[0]), 64'd0);
        cmp("t4_wp_br1", 64'(br_mis[1]), 64'd0);
        cmp("t4_wp_flush1", 64'(flush_o[1]), 64'd1);
        for (int i = 0; i < 4; i++) step(bub, 0, 0, 0);
        cmp("t4_mcnt3", 64'(mcnt[0]), 64'd2);
        cmp("t4_mcnt1", 64'(mcnt[1]), 64'd2);
        cmp("t4_flush3", 64'(flush_o[0]), 64'd0);

        // Reset on the second FLUSH cycle
        step(mk(1, 1, OP_NONE, 5'd0), 64'h8000_0200, 0, 0);
        step(bub, 0, 0, 0);
        step(bub, 0, 0, 0);
        cmp("t5_flush1st", 64'(flush_o[0]), 64'd1);
        step(bub, 0, 0, 1);
        step(mk(1, 0, OP_REG, 5'd9), 64'h99, 0, 0);
        cmp("t5_flushing", 64'(flush_o[0]), 64'd0);
        cmp("t5_instret", instret[0], 64'd0);
        cmp("t5_mcnt", 64'(mcnt[0]), 64'd0);
        step(bub, 0, 0, 0);
        cmp("t5_wr_en", 64'(wr_en[0]), 64'd1);
        cmp("t5_wr_addr", 64'(wr_addr[0]), 64'd9);
        cmp("t5_wr_data", wr_data[0], 64'h99);
        step(bub, 0, 0, 0);
        cmp("t5_instret1", instret[0], 64'd1);
        step(bub, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
